// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the programmable clock-divider bank.
// The half-period helper works in 33 bits, so it supports divisor widths up to 32.
package clk_div_pkg;

  localparam int DW_DEFAULT       = 16;
  localparam int DIV_INIT_DEFAULT = 10;

  // High time of a divide-by-d square wave: ceil(d/2), computed without overflow.
  function automatic logic [32:0] half_period(input logic [31:0] d);
    return (33'(d) + 33'd1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel. It holds the counter, the active and shadow divisors,
// and the registered square wave and tick outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter int DIV_INIT = DIV_INIT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_stb,
  input  logic [DW-1:0] wr_data,
  input  logic          sync,
  output logic          clk_out,
  output logic          tick,
  output logic          pending
);

  logic [DW-1:0] c;
  logic [DW-1:0] d;
  logic [DW-1:0] s;
  logic          boundary;

  // Divisors 0 and 1 have no period to finish, so every cycle is a boundary.
  assign boundary = (d <= DW'(1)) || (c == d - DW'(1));

  // NOTE: all sequential state uses non-blocking assignments, so every branch sees pre-edge values of c, d, s and pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c       <= '0;
      d       <= DW'(DIV_INIT);
      s       <= DW'(DIV_INIT);
      pending <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      // The outputs always decode the pre-edge divisor, even on the cycle it is replaced.
      if (sync) begin
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (d == '0) begin
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (d == DW'(1)) begin
        clk_out <= 1'b1;
        tick    <= 1'b1;
      end else begin
        clk_out <= 33'(c) < half_period(32'(d));
        tick    <= (c == '0);
      end

      if (sync || boundary) begin
        c <= '0;
        if (pending) d <= s;
      end else begin
        c <= c + DW'(1);
      end

      // A write always wins, so a write on a boundary stays queued for the next boundary.
      if (wr_stb) begin
        s       <= wr_data;
        pending <= 1'b1;
      end else if ((sync || boundary) && pending) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH independent programmable integer clock dividers with runtime divisor
// writes that take effect at each channel's period boundary.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int  NCH      = 4,
  parameter int  DW       = DW_DEFAULT,
  parameter int  DIV_INIT = DIV_INIT_DEFAULT,
  localparam int AW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [DW-1:0]  wr_data,
  input  logic           sync,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] pending
);

  logic [NCH-1:0] wr_stb;

  // Only addresses that name a real channel decode, so out-of-range writes fall through.
  always_comb begin
    // NOTE: the default comes first, so the decode cannot infer a latch.
    wr_stb = '0;
    for (int i = 0; i < NCH; i++) begin
      if (wr_en && (wr_addr == AW'(i))) wr_stb[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clk_div_chan #(
      .DW       (DW),
      .DIV_INIT (DIV_INIT)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .wr_stb  (wr_stb[g]),
      .wr_data (wr_data),
      .sync    (sync),
      .clk_out (clk_out[g]),
      .tick    (tick[g]),
      .pending (pending[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomized bench for clk_div_bank. A period-position model of each channel
// predicts clk_out, tick and pending every cycle.
module tb_clk_div_bank;

  localparam int NCH      = 5;
  localparam int DW       = 16;
  localparam int DIV_INIT = 10;
  localparam int AW       = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic           sync;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] pending;

  clk_div_bank #(
    .NCH      (NCH),
    .DW       (DW),
    .DIV_INIT (DIV_INIT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .sync    (sync),
    .clk_out (clk_out),
    .tick    (tick),
    .pending (pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per channel: active divisor, shadow, position within period, pending.
  int             md   [NCH];
  int             ms   [NCH];
  int             mpos [NCH];
  bit             mpend[NCH];
  logic [NCH-1:0] e_clk, e_tick, e_pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      md[i]    = DIV_INIT;
      ms[i]    = DIV_INIT;
      mpos[i]  = 0;
      mpend[i] = 1'b0;
    end
  endfunction

  // Advance the model by one clock edge. The outputs come from the pre-edge position.
  function automatic void model_step(input bit we, input int addr, input int data, input bit sy);
    for (int i = 0; i < NCH; i++) begin
      bit at_end;
      if (sy || md[i] == 0) begin
        e_clk[i]  = 1'b0;
        e_tick[i] = 1'b0;
      end else if (md[i] == 1) begin
        e_clk[i]  = 1'b1;
        e_tick[i] = 1'b1;
      end else begin
        e_clk[i]  = (mpos[i] < (md[i] + 1) / 2);
        e_tick[i] = (mpos[i] == 0);
      end
      at_end = (md[i] <= 1) || (mpos[i] == md[i] - 1);
      if (sy || at_end) begin
        mpos[i] = 0;
        if (mpend[i]) begin
          md[i]    = ms[i];
          mpend[i] = 1'b0;
        end
      end else begin
        mpos[i] = mpos[i] + 1;
      end
      if (we && addr == i) begin
        ms[i]    = data;
        mpend[i] = 1'b1;
      end
      e_pend[i] = mpend[i];
    end
  endfunction

  // This task is called at a falling edge. It drives the inputs, checks after the
  // rising edge, and returns at the next falling edge.
  task automatic cycle(input bit we, input int addr, input int data, input bit sy);
    wr_en   = we;
    wr_addr = AW'(addr);
    wr_data = DW'(data);
    sync    = sy;
    model_step(we, addr, data, sy);
    @(posedge clk);
    #1;
    check("clk_out", 32'(clk_out), 32'(e_clk));
    check("tick",    32'(tick),    32'(e_tick));
    check("pending", 32'(pending), 32'(e_pend));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    int guard;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    sync    = 1'b0;
    #1;
    check("reset_clk_out", 32'(clk_out), 32'd0);
    check("reset_tick",    32'(tick),    32'd0);
    check("reset_pending", 32'(pending), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Default divide-by-10 on every channel.
    idle(25);

    // Channel 1 to divide-by-5, written mid-period.
    idle(3);
    cycle(1'b1, 1, 5, 1'b0);
    check("ch1_pending_set", 32'(pending[1]), 32'd1);
    idle(30);

    // Channel 2 stopped, then forced high.
    cycle(1'b1, 2, 0, 1'b0);
    idle(15);
    cycle(1'b1, 2, 1, 1'b0);
    idle(10);

    // Writes to out-of-range addresses must be ignored.
    cycle(1'b1, 5, 3, 1'b0);
    cycle(1'b1, 6, 3, 1'b0);
    cycle(1'b1, 7, 3, 1'b0);
    check("oor_no_pending", 32'(pending), 32'd0);
    idle(5);

    // Write to channel 3 exactly on its boundary cycle (position 9 of divide-by-10).
    guard = 0;
    while (mpos[3] != 9 && guard < 20) begin
      cycle(1'b0, 0, 0, 1'b0);
      guard++;
    end
    check("boundary_align", 32'(mpos[3]), 32'd9);
    cycle(1'b1, 3, 4, 1'b0);
    check("same_cycle_pending", 32'(pending[3]), 32'd1);
    idle(25);

    // Channels at divisors 3, 7, 10 and 16, then a sync while channel 0 has 6 pending.
    cycle(1'b1, 0, 3, 1'b0);
    cycle(1'b1, 1, 7, 1'b0);
    cycle(1'b1, 2, 10, 1'b0);
    cycle(1'b1, 3, 16, 1'b0);
    idle(40);
    cycle(1'b1, 0, 6, 1'b0);
    cycle(1'b0, 0, 0, 1'b1);
    check("sync_clk_low",  32'(clk_out), 32'd0);
    check("sync_tick_low", 32'(tick),    32'd0);
    cycle(1'b0, 0, 0, 1'b0);
    check("post_sync_aligned", 32'(clk_out & 5'b01111), 32'h0f);
    check("post_sync_pend0",   32'(pending[0]),         32'd0);
    idle(20);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      bit we, sy;
      int addr, data;
      we   = ($urandom_range(0, 7) == 0);
      addr = $urandom_range(0, 7);
      data = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 20);
      sy   = ($urandom_range(0, 59) == 0);
      cycle(we, addr, data, sy);
    end
    idle(2);

    // Asynchronous reset in the middle of a period.
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_clk_out", 32'(clk_out), 32'd0);
    check("async_reset_tick",    32'(tick),    32'd0);
    check("async_reset_pending", 32'(pending), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    idle(25);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised bank of NCH independent integer clock dividers, all clocked from the system clock. Each channel's divisor is loaded at runtime and applied glitch-free at that channel's next period boundary. Each channel produces a registered square wave and a one-cycle tick strobe. The bank replaces fixed divide-by-2/5/10 chains wherever a programmable rate or a clock-enable strobe is needed. Downstream logic uses `tick` as a clock enable; `clk_out` is for pins and slow peripherals only.

## Interface
- NCH, 4: number of channels (≥1).
- DW, 16: divisor and counter width in bits.
- DIV_INIT, 10: divisor loaded into every channel at reset (must fit DW).
- AW, $clog2(NCH) (min 1): address width; derived, not overridden.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  one clock; reset is asynchronous and active-high.
- wr_en  in  1  divisor write strobe.
- wr_addr  in  AW  target channel; values ≥ NCH are ignored.
- wr_data  in  DW  new divisor D.
- sync  in  1  phase-restart all channels.
- clk_out  out  NCH  per-channel divided square wave, registered.
- tick  out  NCH  per-channel one-cycle strobe, once per period.
- pending  out  NCH  per-channel flag: a written divisor is waiting for a boundary.

## Operation
- Per-channel state:
  - counter `c` (DW bits)
  - active divisor `D`
  - shadow divisor `S`
  - `pending` flag
- Reset values (asynchronous): c=0, D=S=DIV_INIT, pending=0, clk_out=0, tick=0.
- Normal mode, D ≥ 2:
  - c ← (c == D−1) ? 0 : c+1.
  - clk_out ← (c < H), where H = (D+1)>>1 computed in DW+1 bits, so high time is ceil(D/2) cycles.
  - tick ← (c == 0).
- D = 1: c held at 0; clk_out ← 1; tick ← 1 every cycle.
- D = 0: channel stopped; c held at 0; clk_out ← 0; tick ← 0.
- Write: wr_en with wr_addr < NCH sets S ← wr_data and pending ← 1. A second write while pending overwrites S; last write wins.
- Boundary: for D ≥ 2, the boundary is the cycle with c == D−1. For D ≤ 1, every cycle is a boundary.
  - If pending at a boundary: D ← S, c ← 0, pending ← 0.
  - The output registers in that cycle still use the old D.
- Write in the same cycle as a boundary:
  - The boundary applies the S value from before the write.
  - The write then sets S to the new value and leaves pending = 1.
  - The new value applies at the following boundary.
- sync (priority over boundary logic), in all channels:
  - c ← 0; clk_out ← 0; tick ← 0.
  - If pending: D ← S and pending ← 0.
  - A write in the same cycle as sync lands in S with pending = 1 and is not applied by that sync.

## Timing
- Output latency: one cycle from counter state to clk_out/tick.
- After reset release, the first edge gives clk_out = 1, tick = 1. With DIV_INIT = 10, the pattern is 5 cycles high, 5 cycles low, repeating.
- After a sync cycle, the next edge evaluates c = 0, so clk_out = 1 and tick = 1 one cycle after the sync cycle's edge. All channels are then phase-aligned.
- pending rises on the edge after wr_en. It falls on the edge that applies S.
- No combinational path from any input to any output.
- Reset asserted mid-period: all outputs drop to their reset values immediately (asynchronous). The shadow value and pending flag are lost.

## Structure
- Package clk_div_pkg:
  - DW default and DIV_INIT default.
  - Helper function computing H = (D+1)>>1 in DW+1 bits.
- Sub-module clk_div_chan:
  - Holds one channel's state: c, D, S, pending, clk_out, tick.
  - Inputs: per-channel write strobe, wr_data, sync.
- clk_div_bank:
  - Address decode generating one write strobe per channel.
  - Generate loop instantiating NCH copies of clk_div_chan.

## Test plan
- Reset, default parameters → every clk_out repeats 5 high / 5 low; tick high once per 10 cycles, in the first cycle of each high phase; pending = 0.
- Write D = 5 to channel 1 mid-period → pending[1] stays 1 until c == 9. After that, clk_out[1] repeats 3 high / 2 low. Other channels are undisturbed.
- Write D = 0 to channel 2, then D = 1 → clk_out[2] goes low and tick[2] goes low the cycle after the apply. After the second write, clk_out[2] holds 1 and tick[2] is 1 every cycle.
- Write to wr_addr = NCH (out of range) → no pending bit set; all outputs unchanged.
- With D = 10, write D = 4 exactly in the cycle c == 9 → the old S (10) is reapplied at that boundary and pending stays 1. D = 4 takes effect 10 cycles later.
- Channels at D = 3, 7, 10, 16 running, then pulse sync with channel 0 pending D = 6 → all clk_out and tick go 0 for one cycle, then rise together. Channel 0 then runs 3 high / 3 low with pending[0] = 0.
